// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings, FSM state type and alignment check for the MFA/MFC memory block.
package mem_pkg;
   localparam logic [1:0] DS_BYTE = 2'b00;
   localparam logic [1:0] DS_HALF = 2'b01;
   localparam logic [1:0] DS_WORD = 2'b10;
   localparam logic [1:0] DS_RSVD = 2'b11;
   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;
   function automatic logic bad_access(input logic [1:0] ds, input logic [1:0] a);
      return (ds == DS_RSVD) || (ds == DS_WORD && a != 2'b00) || (ds == DS_HALF && a[0]);
   endfunction
endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: big-endian byte storage with byte/halfword/word lane mux and demux.
// Ports: CLK clock; we write strobe; addr byte address; ds size; wdata right-justified
// write data; rdata combinational zero-extended read of the addressed lanes.
module mem_byte_array
   import mem_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        ds,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);
   // Not reset: contents survive Reset and are preloaded/dumped hierarchically.
   logic [7:0] Mem [0:DEPTH-1];
   logic [ADDR_W-1:0] a1, a2, a3;
   // Lane offsets wrap modulo DEPTH through the ADDR_W-bit adds.
   assign a1 = addr + ADDR_W'(1);
   assign a2 = addr + ADDR_W'(2);
   assign a3 = addr + ADDR_W'(3);
   assign rdata = (ds == DS_BYTE) ? {24'b0, Mem[addr]} :
                  (ds == DS_HALF) ? {16'b0, Mem[addr], Mem[a1]} :
                                    {Mem[addr], Mem[a1], Mem[a2], Mem[a3]};
   always_ff @(posedge CLK) begin
      if (we) begin
         if (ds == DS_BYTE) begin
            Mem[addr] <= wdata[7:0];
         end else if (ds == DS_HALF) begin
            Mem[addr] <= wdata[15:8];
            Mem[a1]   <= wdata[7:0];
         end else begin
            Mem[addr] <= wdata[31:24];
            Mem[a1]   <= wdata[23:16];
            Mem[a2]   <= wdata[15:8];
            Mem[a3]   <= wdata[7:0];
         end
      end
   end
endmodule

// File: rtl/mem_ctrl_mfc.sv
// mem_ctrl_mfc: MFA/MFC handshaked byte-addressed memory with programmable wait states.
// Ports: CLK clock; Reset async active-low; MFA request; RW 1=write; DS size;
// Address byte address; DataIn write data; DataOut read data; MFC complete;
// ERR completed request was misaligned or reserved size.
module mem_ctrl_mfc
   import mem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              MFA,
   input  logic              RW,
   input  logic [1:0]        DS,
   input  logic [ADDR_W-1:0] Address,
   input  logic [31:0]       DataIn,
   output logic [31:0]       DataOut,
   output logic              MFC,
   output logic              ERR
);
   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rw_q, rw_d;
   logic [1:0]        ds_q, ds_d;
   logic [31:0]       din_q, din_d, dout_q, dout_d, rdata;
   logic              err_q, err_d, access, bad, we;

   mem_byte_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .CLK  (CLK),
      .we   (we),
      .addr (addr_q),
      .ds   (ds_q),
      .wdata(din_q),
      .rdata(rdata)
   );

   assign bad = bad_access(ds_q, addr_q[1:0]);
   assign we  = access && rw_q == RW_WRITE && !bad;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rw_d    = rw_q;
      ds_d    = ds_q;
      din_d   = din_q;
      dout_d  = dout_q;
      err_d   = err_q;
      access  = 1'b0;
      case (state_q)
         ST_IDLE: if (MFA) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
            addr_d  = Address;
            rw_d    = RW;
            ds_d    = DS;
            din_d   = DataIn;
            err_d   = 1'b0;
         end
         ST_WAIT: begin
            if (!MFA) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               access  = 1'b1;
               err_d   = bad;
               dout_d  = bad ? 32'b0 : (rw_q == RW_READ ? rdata : dout_q);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: if (!MFA) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rw_q    <= RW_READ;
         ds_q    <= DS_BYTE;
         din_q   <= '0;
         dout_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         ds_q    <= ds_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         err_q   <= err_d;
      end
   end

   assign DataOut = dout_q;
   assign MFC     = state_q == ST_DONE;
   assign ERR     = err_q;
endmodule

// File: tb/tb_mem_ctrl_mfc.sv
// tb_mem_ctrl_mfc: directed self-checking bench for mem_ctrl_mfc (WAIT_CYCLES=2 and 0).
module tb_mem_ctrl_mfc;
   logic        CLK = 1'b0, Reset = 1'b0;
   logic        MFA = 1'b0, RW = 1'b0;
   logic [1:0]  DS = 2'b00;
   logic [7:0]  Address = 8'h00;
   logic [31:0] DataIn = 32'h0, DataOut;
   logic        MFC, ERR;
   logic        mfa0 = 1'b0, mfc0, err0;
   logic        rw0 = 1'b0;
   logic [1:0]  ds0 = 2'b10;
   logic [7:0]  addr0 = 8'h00;
   logic [31:0] din0 = 32'h0, dout0;
   int tests = 0, fails = 0;

   always #5 CLK = ~CLK;

   mem_ctrl_mfc #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
      .CLK(CLK), .Reset(Reset), .MFA(MFA), .RW(RW), .DS(DS), .Address(Address),
      .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .ERR(ERR));

   mem_ctrl_mfc #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
      .CLK(CLK), .Reset(Reset), .MFA(mfa0), .RW(rw0), .DS(ds0), .Address(addr0),
      .DataIn(din0), .DataOut(dout0), .MFC(mfc0), .ERR(err0));

   task automatic req(input logic rw, input logic [1:0] ds, input logic [7:0] a,
                      input logic [31:0] d, output int lat);
      @(negedge CLK);
      MFA = 1'b1; RW = rw; DS = ds; Address = a; DataIn = d;
      lat = 99;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         if (MFC) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic release_mfa();
      @(negedge CLK);
      MFA = 1'b0;
      @(posedge CLK); #1;
   endtask

   function automatic logic [31:0] word_at(input logic [7:0] a);
      return {dut.u_mem.Mem[a], dut.u_mem.Mem[a+8'd1], dut.u_mem.Mem[a+8'd2], dut.u_mem.Mem[a+8'd3]};
   endfunction

   task automatic test_reset();
      repeat (2) @(posedge CLK);
      #1;
      tests++; if (MFC !== 1'b0) begin fails++; $display("FAIL reset_mfc got %b want 0", MFC); end
      tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", ERR); end
      tests++; if (DataOut !== 32'h0) begin fails++; $display("FAIL reset_dout got %h want 0", DataOut); end
      @(negedge CLK);
      Reset = 1'b1;
   endtask

   task automatic test_word();
      int lat;
      req(1'b1, 2'b10, 8'h10, 32'hDEADBEEF, lat);
      tests++; if (lat !== 3) begin fails++; $display("FAIL wr_latency got %0d want 3", lat); end
      tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL wr_err got %b want 0", ERR); end
      tests++; if (DataOut !== 32'h0) begin fails++; $display("FAIL wr_dout_kept got %h want 0", DataOut); end
      tests++; if (word_at(8'h10) !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_mem got %h want deadbeef", word_at(8'h10)); end
      release_mfa();
      tests++; if (MFC !== 1'b0) begin fails++; $display("FAIL mfc_fall got %b want 0", MFC); end
      req(1'b0, 2'b10, 8'h10, 32'h0, lat);
      tests++; if (lat !== 3) begin fails++; $display("FAIL rd_latency got %0d want 3", lat); end
      tests++; if (DataOut !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_word got %h want deadbeef", DataOut); end
      release_mfa();
   endtask

   task automatic test_subword();
      int lat;
      req(1'b0, 2'b00, 8'h11, 32'h0, lat);
      tests++; if (DataOut !== 32'h000000AD) begin fails++; $display("FAIL rd_byte got %h want 000000ad", DataOut); end
      release_mfa();
      req(1'b1, 2'b01, 8'h12, 32'hFFFF1234, lat);
      release_mfa();
      req(1'b0, 2'b01, 8'h12, 32'h0, lat);
      tests++; if (DataOut !== 32'h00001234) begin fails++; $display("FAIL rd_half got %h want 00001234", DataOut); end
      release_mfa();
      req(1'b0, 2'b10, 8'h10, 32'h0, lat);
      tests++; if (DataOut !== 32'hDEAD1234) begin fails++; $display("FAIL rd_after_half got %h want dead1234", DataOut); end
      release_mfa();
   endtask

   task automatic test_misalign();
      int lat;
      req(1'b1, 2'b10, 8'h21, 32'h11223344, lat);
      tests++; if (lat !== 3) begin fails++; $display("FAIL mis_latency got %0d want 3", lat); end
      tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL mis_err got %b want 1", ERR); end
      tests++; if (DataOut !== 32'h0) begin fails++; $display("FAIL mis_dout got %h want 0", DataOut); end
      tests++; if (word_at(8'h20) !== 32'hDFDEDDDC || dut.u_mem.Mem[8'h24] !== 8'hDB) begin
         fails++; $display("FAIL mis_mem got %h want dfdedddc", word_at(8'h20)); end
      release_mfa();
      tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL err_hold got %b want 1", ERR); end
      req(1'b0, 2'b10, 8'h20, 32'h0, lat);
      tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL aligned_err got %b want 0", ERR); end
      tests++; if (DataOut !== 32'hDFDEDDDC) begin fails++; $display("FAIL aligned_rd got %h want dfdedddc", DataOut); end
      release_mfa();
      req(1'b0, 2'b01, 8'h23, 32'h0, lat);
      tests++; if (ERR !== 1'b1 || DataOut !== 32'h0) begin fails++; $display("FAIL half_odd got err=%b dout=%h want err=1 dout=0", ERR, DataOut); end
      release_mfa();
      req(1'b1, 2'b11, 8'h20, 32'hAAAAAAAA, lat);
      tests++; if (ERR !== 1'b1 || word_at(8'h20) !== 32'hDFDEDDDC) begin
         fails++; $display("FAIL ds_rsvd got err=%b mem=%h want err=1 mem=dfdedddc", ERR, word_at(8'h20)); end
      release_mfa();
      req(1'b0, 2'b00, 8'h23, 32'h0, lat);
      tests++; if (ERR !== 1'b0 || DataOut !== 32'h000000DC) begin fails++; $display("FAIL byte_odd got err=%b dout=%h want err=0 dout=000000dc", ERR, DataOut); end
      release_mfa();
   endtask

   task automatic test_abort();
      logic seen;
      seen = 1'b0;
      @(negedge CLK);
      MFA = 1'b1; RW = 1'b1; DS = 2'b10; Address = 8'h30; DataIn = 32'h55667788;
      @(posedge CLK);
      @(negedge CLK);
      MFA = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK); #1;
         if (MFC) seen = 1'b1;
      end
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_mfc got %b want 0", seen); end
      tests++; if (word_at(8'h30) !== 32'hCFCECDCC) begin fails++; $display("FAIL abort_mem got %h want cfcecdcc", word_at(8'h30)); end
      tests++; if (DataOut !== 32'h000000DC) begin fails++; $display("FAIL abort_dout got %h want 000000dc", DataOut); end
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge CLK);
      MFA = 1'b1; RW = 1'b1; DS = 2'b10; Address = 8'h40; DataIn = 32'hCAFEF00D;
      @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      #1;
      tests++; if (MFC !== 1'b0 || ERR !== 1'b0 || DataOut !== 32'h0) begin
         fails++; $display("FAIL rst_mid got mfc=%b err=%b dout=%h want 0 0 0", MFC, ERR, DataOut); end
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      MFA = 1'b0;
      Reset = 1'b1;
      #1;
      tests++; if (word_at(8'h40) !== 32'hBFBEBDBC) begin fails++; $display("FAIL rst_mem got %h want bfbebdbc", word_at(8'h40)); end
      req(1'b0, 2'b10, 8'h40, 32'h0, lat);
      tests++; if (lat !== 3 || DataOut !== 32'hBFBEBDBC) begin
         fails++; $display("FAIL rst_rd got lat=%0d dout=%h want 3 bfbebdbc", lat, DataOut); end
      release_mfa();
   endtask

   task automatic test_held();
      int lat;
      logic stay;
      stay = 1'b1;
      req(1'b1, 2'b00, 8'h50, 32'h00000077, lat);
      DataIn = 32'h00000099;
      Address = 8'h51;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         if (!MFC) stay = 1'b0;
      end
      tests++; if (stay !== 1'b1) begin fails++; $display("FAIL held_mfc got %b want 1", stay); end
      tests++; if (dut.u_mem.Mem[8'h50] !== 8'h77 || dut.u_mem.Mem[8'h51] !== 8'hAE) begin
         fails++; $display("FAIL held_once got %h %h want 77 ae", dut.u_mem.Mem[8'h50], dut.u_mem.Mem[8'h51]); end
      release_mfa();
   endtask

   task automatic test_wait0();
      int lat;
      @(negedge CLK);
      mfa0 = 1'b1; rw0 = 1'b0; ds0 = 2'b10; addr0 = 8'h04;
      lat = 99;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         if (mfc0) begin
            lat = i;
            break;
         end
      end
      tests++; if (lat !== 1) begin fails++; $display("FAIL w0_latency got %0d want 1", lat); end
      tests++; if (dout0 !== 32'hFBFAF9F8 || err0 !== 1'b0) begin
         fails++; $display("FAIL w0_rd got dout=%h err=%b want fbfaf9f8 0", dout0, err0); end
      @(negedge CLK);
      mfa0 = 1'b0;
      @(posedge CLK); #1;
      tests++; if (mfc0 !== 1'b0) begin fails++; $display("FAIL w0_fall got %b want 0", mfc0); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         dut.u_mem.Mem[i]  = ~8'(i);
         dut0.u_mem.Mem[i] = ~8'(i);
      end
      test_reset();
      test_word();
      test_subword();
      test_misalign();
      test_abort();
      test_reset_mid();
      test_held();
      test_wait0();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
